// File: rtl/clk_period_mon.sv
// Clock-quality monitor: measures high time and period of clk_in in clk cycles, checks tolerance, tracks lock/error/timeout.
// Optional build macro CLK_MON_SYNC_EN inserts a 2-flop synchronizer ahead of the sampling register.
module clk_period_mon #(
  parameter int unsigned EXP_HIGH = 5,
  parameter int unsigned EXP_LOW  = 5,
  parameter int unsigned TOL      = 1,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TIMEOUT  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int unsigned LOCK_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  EXP_H  = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  EXP_L  = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0]  TOL_V  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  TO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_V = LOCK_W'(LOCK_N);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  state_t             r_state, w_next_state;
  logic               w_sample;
  logic               r_s, r_s_d;
  logic               w_rise, w_fall;
  logic [CNT_W-1:0]   r_hcnt, r_lcnt;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic [CNT_W-1:0]   r_high_len, r_period;
  logic               r_meas_valid, r_err, r_timeout;
  logic               w_publish, w_h_to, w_l_to, w_to_hit, w_good, w_bad;
  logic [CNT_W-1:0]   w_hdiff, w_ldiff;
  logic [CNT_W:0]     w_sum;
  logic [CNT_W-1:0]   w_period_sat;

`ifdef CLK_MON_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[0], clk_in};
  end
  assign w_sample = r_sync[1];
`else
  assign w_sample = clk_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s   <= 1'b0;
      r_s_d <= 1'b0;
    end else begin
      r_s   <= w_sample;
      r_s_d <= r_s;
    end
  end

  assign w_rise = r_s & ~r_s_d;
  assign w_fall = ~r_s & r_s_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves the signal unassigned (latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_next_state = ST_HIGH;
      ST_HIGH: if (w_h_to) w_next_state = ST_IDLE;
               else if (w_fall) w_next_state = ST_LOW;
      ST_LOW:  if (w_l_to) w_next_state = ST_IDLE;
               else if (w_rise) w_next_state = ST_HIGH;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_h_to    = (r_state == ST_HIGH) && r_s && (r_hcnt == TO_M1);
    w_l_to    = (r_state == ST_LOW) && !r_s && (r_lcnt == TO_M1);
    w_to_hit  = w_h_to | w_l_to;
    w_publish = (r_state == ST_LOW) && w_rise;
    w_hdiff   = (r_hcnt >= EXP_H) ? (r_hcnt - EXP_H) : (EXP_H - r_hcnt);
    w_ldiff   = (r_lcnt >= EXP_L) ? (r_lcnt - EXP_L) : (EXP_L - r_lcnt);
    w_good    = (w_hdiff <= TOL_V) && (w_ldiff <= TOL_V);
    w_bad     = w_publish && !w_good;
    w_sum     = {1'b0, r_hcnt} + {1'b0, r_lcnt};
    w_period_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  // The rise and fall cycles themselves count toward the phase they start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hcnt <= w_rise ? ONE : '0;
          r_lcnt <= '0;
        end
        ST_HIGH: begin
          if (w_h_to) begin
            r_hcnt <= '0;
            r_lcnt <= '0;
          end else if (r_s) r_hcnt <= r_hcnt + ONE;
          else              r_lcnt <= r_lcnt + ONE;
        end
        ST_LOW: begin
          if (w_rise) begin
            r_hcnt <= ONE;
            r_lcnt <= '0;
          end else if (w_l_to) begin
            r_hcnt <= '0;
            r_lcnt <= '0;
          end else r_lcnt <= r_lcnt + ONE;
        end
        default: begin
          r_hcnt <= '0;
          r_lcnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_high_len   <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_lock_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_meas_valid <= w_publish;
      r_timeout    <= w_to_hit;
      if (w_publish) begin
        r_high_len <= r_hcnt;
        r_period   <= w_period_sat;
      end
      if (w_to_hit || w_bad)                 r_lock_cnt <= '0;
      else if (w_publish && r_lock_cnt != LOCK_V) r_lock_cnt <= r_lock_cnt + 1'b1;
      // A new error outranks a coincident clear.
      if (w_to_hit || w_bad) r_err <= 1'b1;
      else if (err_clr)      r_err <= 1'b0;
    end
  end

  assign high_len   = r_high_len;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;
  assign err        = r_err;
  assign locked     = (r_lock_cnt == LOCK_V);

endmodule

// File: tb/tb_clk_period_mon.sv
// Directed bench for clk_period_mon: drives clk_in phase patterns and checks strobed measurements, lock, error and timeout.
module tb_clk_period_mon;

`ifdef CLK_MON_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_in;
  logic       err_clr;
  logic [7:0] high_len, period;
  logic       meas_valid, locked, err, timeout;

  typedef struct {
    logic [7:0] hl;
    logic [7:0] p;
    logic       lk;
    logic       er;
  } strobe_t;

  strobe_t q[$];
  int n_checks = 0;
  int n_errs   = 0;
  int n_to     = 0;

  clk_period_mon dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .err_clr(err_clr),
    .high_len(high_len), .period(period), .meas_valid(meas_valid),
    .locked(locked), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) q.push_back('{high_len, period, locked, err});
    if (timeout === 1'b1) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int l);
    repeat (h) begin @(negedge clk); clk_in = 1'b1; end
    repeat (l) begin @(negedge clk); clk_in = 1'b0; end
  endtask

  task automatic expect_strobe(input string tag, input int hl, input int p, input logic lk, input logic er);
    strobe_t s;
    check({tag, "_present"}, 32'(q.size() > 0), 1);
    if (q.size() > 0) begin
      s = q.pop_front();
      check({tag, "_high_len"}, 32'(s.hl), 32'(hl));
      check({tag, "_period"},   32'(s.p),  32'(p));
      check({tag, "_locked"},   32'(s.lk), 32'(lk));
      check({tag, "_err"},      32'(s.er), 32'(er));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_high_len"},   32'(high_len),   0);
    check({tag, "_period"},     32'(period),     0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 0);
    check({tag, "_locked"},     32'(locked),     0);
    check({tag, "_err"},        32'(err),        0);
    check({tag, "_timeout"},    32'(timeout),    0);
  endtask

  initial begin
    rst = 1'b1; clk_in = 1'b0; err_clr = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal 5/5: first rise only arms, lock at the 4th strobe.
    repeat (6) drive(5, 5);
    for (int i = 1; i <= 5; i++) expect_strobe($sformatf("nom%0d", i), 5, 10, (i >= 4), 1'b0);
    check("nom_err", 32'(err), 0);

    // One 7/5 period breaks lock and sets err, then relock over 4 good periods.
    drive(7, 5);
    expect_strobe("nom6", 5, 10, 1'b1, 1'b0);
    repeat (4) drive(5, 5);
    expect_strobe("bad7", 7, 12, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) expect_strobe($sformatf("relock%0d", i), 5, 10, 1'b0, 1'b1);
    repeat (2) drive(6, 4);
    expect_strobe("relock4", 5, 10, 1'b1, 1'b1);
    expect_strobe("edge64", 6, 10, 1'b1, 1'b1);
    check("q_empty1", 32'(q.size()), 0);

    // Lone err_clr (stretches the current low phase to 6, still in tolerance).
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("errclr_alone", 32'(err), 0);

    // Stuck high: 6/6 period closes, then timeout after 200 high cycles.
    drive(205, 0);
    expect_strobe("pre_to", 6, 12, 1'b1, 1'b0);
    check("to_pulses", 32'(n_to), 1);
    check("to_err", 32'(err), 1);
    check("to_locked", 32'(locked), 0);
    check("to_strobe_low", 32'(timeout), 0);
    check("q_empty2", 32'(q.size()), 0);

    // Resume: first rise re-arms without a strobe, lock rebuilds from zero.
    drive(0, 5);
    repeat (5) drive(5, 5);
    drive(5, 3);
    for (int i = 1; i <= 5; i++) expect_strobe($sformatf("resume%0d", i), 5, 10, (i >= 4), 1'b1);
    check("pre_rst_locked", 32'(locked), 1);

    // Reset in the low phase while locked.
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("q_empty3", 32'(q.size()), 0);
    repeat (3) drive(5, 5);
    expect_strobe("post_rst1", 5, 10, 1'b0, 1'b0);
    expect_strobe("post_rst2", 5, 10, 1'b0, 1'b0);

    // err_clr coinciding with the strobe of a bad 8/5 period.
    drive(8, 5);
    expect_strobe("post_rst3", 5, 10, 1'b0, 1'b0);
    @(negedge clk); clk_in = 1'b1;
    repeat (SYNC_LAT) @(negedge clk);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("coinc_strobe", 32'(meas_valid), 1);
    check("coinc_err", 32'(err), 1);
    drive(2, 5);
    expect_strobe("coinc_bad", 8, 13, 1'b0, 1'b1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("late_clr", 32'(err), 0);
    check("q_empty4", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
